// File: rtl/rnn_mem_host_if.sv
// Memory bus between the RNN engine/host requesters and the rnn_mem_host responder.
// Carries the engine bank port (mce/msel/maddr/mdata_*) and the host access port (hst_*).
interface rnn_mem_host_if;
    logic        mce;
    logic [2:0]  msel;
    logic [16:0] maddr;
    logic [19:0] mdata_w;
    logic [19:0] mdata_r;
    logic        hst_en;
    logic        hst_we;
    logic [2:0]  hst_sel;
    logic [16:0] hst_addr;
    logic [19:0] hst_wdata;
    logic [19:0] hst_rdata;
    logic        hst_ack;

    modport master (
        output mce, msel, maddr, mdata_w,
        output hst_en, hst_we, hst_sel, hst_addr, hst_wdata,
        input  mdata_r, hst_rdata, hst_ack
    );

    modport slave (
        input  mce, msel, maddr, mdata_w,
        input  hst_en, hst_we, hst_sel, hst_addr, hst_wdata,
        output mdata_r, hst_rdata, hst_ack
    );
endinterface

// File: rtl/rnn_mem_host.sv
// Responder for the RNN engine: parameter banks, output capture bank, input-vector FIFO
// and the run sequencer (ready/busy/done), plus a host port usable while the engine is idle.
module rnn_mem_host #(
    parameter int MAX_T       = 16,
    parameter int XFIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 ready,
    input  logic                 busy,
    input  logic                 i_en,
    output logic [31:0]          idata,
    rnn_mem_host_if.slave        bus,
    input  logic                 x_valid,
    input  logic [31:0]          x_data,
    output logic                 x_ready,
    output logic                 done,
    output logic [16:0]          wr_count,
    output logic [1:0]           err
);

    localparam int          TW        = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int          OW        = TW + 6;
    localparam int          OUT_WORDS = MAX_T * 64;
    localparam logic [10:0] T_LIMIT   = 11'(MAX_T);
    localparam int          PW        = (XFIFO_DEPTH > 1) ? $clog2(XFIFO_DEPTH) : 1;
    localparam logic [PW:0] FIFO_FULL = (PW + 1)'(XFIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_RUN, S_DONE} state_t;

    state_t      state;
    logic [2:0]  wait_cnt;

    logic [19:0] w_ih    [2048];
    logic [19:0] b_ih    [64];
    logic [19:0] w_hh    [4096];
    logic [19:0] b_hh    [64];
    logic [19:0] cfg;
    logic [19:0] out_mem [OUT_WORDS];

    logic          eng_out_wr, eng_t_ok;
    logic [OW-1:0] eng_oidx;
    logic          host_acc, host_wr, hst_t_ok;
    logic [OW-1:0] hst_oidx;
    logic [19:0]   eng_rd, hst_rd;

    assign eng_t_ok   = bus.maddr[16:6] < T_LIMIT;
    assign eng_oidx   = {bus.maddr[6+TW-1:6], bus.maddr[5:0]};
    assign eng_out_wr = !reset && bus.mce && (bus.msel == 3'b101);

    assign host_acc = bus.hst_en && (state == S_IDLE || state == S_DONE);
    assign host_wr  = !reset && host_acc && bus.hst_we;
    assign hst_t_ok = bus.hst_addr[16:6] < T_LIMIT;
    assign hst_oidx = {bus.hst_addr[6+TW-1:6], bus.hst_addr[5:0]};

    always_comb begin
        eng_rd = '0;
        case (bus.msel)
            3'b000:  eng_rd = w_ih[bus.maddr[10:0]];
            3'b001:  eng_rd = b_ih[bus.maddr[5:0]];
            3'b010:  eng_rd = w_hh[bus.maddr[11:0]];
            3'b011:  eng_rd = b_hh[bus.maddr[5:0]];
            3'b100:  eng_rd = cfg;
            default: eng_rd = '0;
        endcase
    end

    always_comb begin
        hst_rd = '0;
        case (bus.hst_sel)
            3'b000:  hst_rd = w_ih[bus.hst_addr[10:0]];
            3'b001:  hst_rd = b_ih[bus.hst_addr[5:0]];
            3'b010:  hst_rd = w_hh[bus.hst_addr[11:0]];
            3'b011:  hst_rd = b_hh[bus.hst_addr[5:0]];
            3'b100:  hst_rd = cfg;
            3'b101:  hst_rd = hst_t_ok ? out_mem[hst_oidx] : '0;
            default: hst_rd = '0;
        endcase
    end

    // Bank contents survive reset; writes in a reset cycle are dropped. Engine wins the output bank.
    always_ff @(posedge clk) begin
        if (eng_out_wr && eng_t_ok)
            out_mem[eng_oidx] <= bus.mdata_w;
        else if (host_wr && bus.hst_sel == 3'b101 && hst_t_ok)
            out_mem[hst_oidx] <= bus.hst_wdata;
        if (host_wr) begin
            case (bus.hst_sel)
                3'b000:  w_ih[bus.hst_addr[10:0]] <= bus.hst_wdata;
                3'b001:  b_ih[bus.hst_addr[5:0]]  <= bus.hst_wdata;
                3'b010:  w_hh[bus.hst_addr[11:0]] <= bus.hst_wdata;
                3'b011:  b_hh[bus.hst_addr[5:0]]  <= bus.hst_wdata;
                3'b100:  cfg                      <= bus.hst_wdata;
                default: ;
            endcase
        end
    end

    // Input-vector FIFO with a registered head (idata)
    logic [31:0]   xmem [XFIFO_DEPTH];
    logic [PW-1:0] rptr, wptr, rptr_n;
    logic [PW:0]   cnt, cnt_n;
    logic          push, pop, fifo_empty;
    logic [31:0]   head_n;

    assign fifo_empty = (cnt == '0);
    assign push       = x_valid && x_ready;
    assign pop        = i_en && !fifo_empty;

    always_comb begin
        cnt_n = cnt;
        if (push && !pop)
            cnt_n = cnt + (PW + 1)'(1);
        else if (pop && !push)
            cnt_n = cnt - (PW + 1)'(1);
        rptr_n = pop ? rptr + PW'(1) : rptr;
        head_n = '0;
        // When the only remaining entry is the one being pushed now, it is not in xmem yet.
        if (cnt_n != '0)
            head_n = (fifo_empty || (pop && cnt == (PW + 1)'(1))) ? x_data : xmem[rptr_n];
    end

    always_ff @(posedge clk) begin
        if (push && !reset)
            xmem[wptr] <= x_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr    <= '0;
            wptr    <= '0;
            cnt     <= '0;
            idata   <= '0;
            x_ready <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            rptr    <= rptr_n;
            cnt     <= cnt_n;
            idata   <= head_n;
            x_ready <= (cnt_n != FIFO_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            ready         <= 1'b0;
            done          <= 1'b0;
            wr_count      <= '0;
            err           <= '0;
            bus.mdata_r   <= '0;
            bus.hst_rdata <= '0;
            bus.hst_ack   <= 1'b0;
        end else begin
            ready       <= 1'b0;
            done        <= 1'b0;
            bus.hst_ack <= host_acc;
            if (bus.mce && bus.msel != 3'b101)
                bus.mdata_r <= eng_rd;
            if (host_acc && !bus.hst_we)
                bus.hst_rdata <= hst_rd;
            if (eng_out_wr) begin
                if (eng_t_ok)
                    wr_count <= wr_count + 17'd1;
                else
                    err[1] <= 1'b1;
            end
            if (i_en && fifo_empty)
                err[0] <= 1'b1;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        wr_count <= '0;
                        state    <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!fifo_empty) begin
                        ready    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Re-strobe ready after four idle cycles following the previous pulse.
                    if (busy) begin
                        state <= S_RUN;
                    end else if (wait_cnt == 3'd4) begin
                        ready    <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_RUN: begin
                    if (!busy) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rnn_mem_host.sv
// Directed bench for rnn_mem_host: bank table via host and engine ports, then
// hand-written run sequences (ready re-pulse, busy lockout, output writes, FIFO, mid-run reset).
module tb_rnn_mem_host;

    logic        clk = 1'b0;
    logic        reset, start, busy, i_en, x_valid;
    logic [31:0] x_data, idata;
    logic        ready, x_ready, done;
    logic [16:0] wr_count;
    logic [1:0]  err;

    int checks   = 0;
    int failures = 0;

    rnn_mem_host_if bus ();

    rnn_mem_host #(.MAX_T(16), .XFIFO_DEPTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ready    (ready),
        .busy     (busy),
        .i_en     (i_en),
        .idata    (idata),
        .bus      (bus),
        .x_valid  (x_valid),
        .x_data   (x_data),
        .x_ready  (x_ready),
        .done     (done),
        .wr_count (wr_count),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [16:0] waddr;
        logic [19:0] wdata;
        logic [16:0] raddr;
        logic [19:0] exp;
        logic        chk_e;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic host_write(input logic [2:0] sel, input logic [16:0] addr,
                              input logic [19:0] data, output logic ack);
        bus.hst_en = 1'b1; bus.hst_we = 1'b1;
        bus.hst_sel = sel; bus.hst_addr = addr; bus.hst_wdata = data;
        @(negedge clk);
        ack = bus.hst_ack;
        bus.hst_en = 1'b0; bus.hst_we = 1'b0;
    endtask

    task automatic host_read(input logic [2:0] sel, input logic [16:0] addr,
                             output logic [19:0] data, output logic ack);
        bus.hst_en = 1'b1; bus.hst_we = 1'b0;
        bus.hst_sel = sel; bus.hst_addr = addr;
        @(negedge clk);
        ack  = bus.hst_ack;
        data = bus.hst_rdata;
        bus.hst_en = 1'b0;
    endtask

    task automatic eng_read(input logic [2:0] sel, input logic [16:0] addr, output logic [19:0] data);
        bus.mce = 1'b1; bus.msel = sel; bus.maddr = addr;
        @(negedge clk);
        data = bus.mdata_r;
        bus.mce = 1'b0;
    endtask

    task automatic eng_write(input logic [16:0] addr, input logic [19:0] data);
        bus.mce = 1'b1; bus.msel = 3'b101; bus.maddr = addr; bus.mdata_w = data;
        @(negedge clk);
        bus.mce = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        int n = 0;
        while (!x_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("push_x_ready", x_ready, 1);
        x_valid = 1'b1; x_data = d;
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic pop_once();
        i_en = 1'b1;
        @(negedge clk);
        i_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic        ack, seen;
        logic [19:0] rd;

        reset = 1'b1; start = 1'b0; busy = 1'b0; i_en = 1'b0; x_valid = 1'b0; x_data = '0;
        bus.mce = 1'b0; bus.msel = '0; bus.maddr = '0; bus.mdata_w = '0;
        bus.hst_en = 1'b0; bus.hst_we = 1'b0; bus.hst_sel = '0; bus.hst_addr = '0; bus.hst_wdata = '0;

        vecs[0] = '{3'd0, 17'h00065, 20'h0ABCD, 17'h00065, 20'h0ABCD, 1'b1};
        vecs[1] = '{3'd1, 17'h0003F, 20'h11111, 17'h0003F, 20'h11111, 1'b1};
        vecs[2] = '{3'd1, 17'h000C2, 20'h22222, 17'h00002, 20'h22222, 1'b1};
        vecs[3] = '{3'd2, 17'h00FFF, 20'hFFFFF, 17'h00FFF, 20'hFFFFF, 1'b1};
        vecs[4] = '{3'd2, 17'h10ABC, 20'h0A0A0, 17'h00ABC, 20'h0A0A0, 1'b1};
        vecs[5] = '{3'd3, 17'h00000, 20'h33333, 17'h00000, 20'h33333, 1'b1};
        vecs[6] = '{3'd4, 17'h00000, 20'h00010, 17'h00005, 20'h00010, 1'b1};
        vecs[7] = '{3'd6, 17'h00010, 20'h77777, 17'h00010, 20'h00000, 1'b1};
        vecs[8] = '{3'd7, 17'h00000, 20'h12121, 17'h00000, 20'h00000, 1'b1};
        vecs[9] = '{3'd5, 17'h003C1, 20'h55555, 17'h003C1, 20'h55555, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
        check("rst_idata", idata, 0);
        check("rst_err", err, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_mdata_r", bus.mdata_r, 0);
        check("rst_hst_ack", bus.hst_ack, 0);
        check("rst_x_ready", x_ready, 0);
        @(negedge clk);
        check("x_ready_after_rst", x_ready, 1);

        for (int i = 0; i < 10; i++) begin
            host_write(vecs[i].sel, vecs[i].waddr, vecs[i].wdata, ack);
            check($sformatf("tbl_wr_ack_%0d", i), ack, 1);
        end
        for (int i = 0; i < 10; i++) begin
            host_read(vecs[i].sel, vecs[i].raddr, rd, ack);
            check($sformatf("tbl_rd_ack_%0d", i), ack, 1);
            check($sformatf("tbl_host_rd_%0d", i), rd, vecs[i].exp);
            if (vecs[i].chk_e) begin
                eng_read(vecs[i].sel, vecs[i].raddr, rd);
                check($sformatf("tbl_eng_rd_%0d", i), rd, vecs[i].exp);
            end
        end

        eng_read(3'd0, 17'h00065, rd);
        check("eng_rd_wih", rd, 20'h0ABCD);
        bus.msel = 3'd1; bus.maddr = 17'h0003F;
        @(negedge clk);
        check("mdata_r_hold_mce0", bus.mdata_r, 20'h0ABCD);

        push(32'h1); push(32'h2); push(32'h3);
        check("idata_head_1", idata, 32'h1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_seen", ready, 1);
        check("ready_latency", n, 1);
        @(negedge clk);
        check("ready_one_cycle", ready, 0);
        n = 1;
        while (!ready && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("ready_repulse_gap", n, 5);
        busy = 1'b1;
        @(negedge clk);

        check("run_idata", idata, 32'h1);
        pop_once();
        check("idata_after_pop", idata, 32'h2);

        seen = 1'b0;
        bus.hst_en = 1'b1; bus.hst_we = 1'b1; bus.hst_sel = 3'd0;
        bus.hst_addr = 17'h00065; bus.hst_wdata = 20'h99999;
        repeat (3) begin
            @(negedge clk);
            if (bus.hst_ack) seen = 1'b1;
        end
        bus.hst_en = 1'b0; bus.hst_we = 1'b0;
        check("hst_ack_blocked_busy", seen, 0);
        eng_read(3'd0, 17'h00065, rd);
        check("bank_unchanged_busy", rd, 20'h0ABCD);

        eng_write(17'h000BF, 20'h10000);
        check("mdata_r_hold_on_write", bus.mdata_r, 20'h0ABCD);
        eng_write(17'h00400, 20'h12345);
        check("err_out_of_range", err, 2'b10);
        check("done_low_in_run", done, 0);

        busy = 1'b0;
        n = 0;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        check("done_latency", n, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        host_write(3'd0, 17'h00065, 20'h99999, ack);
        check("retry_ack", ack, 1);
        eng_read(3'd0, 17'h00065, rd);
        check("retry_written", rd, 20'h99999);
        host_read(3'd5, 17'h000BF, rd, ack);
        check("out_readback", rd, 20'h10000);
        host_read(3'd5, 17'h00400, rd, ack);
        check("out_range_dropped", rd, 20'h0);
        check("wr_count_run1", wr_count, 1);
        host_write(3'd5, 17'h00000, 20'h0F0F0, ack);

        check("x_ready_pushpop", x_ready, 1);
        x_valid = 1'b1; x_data = 32'h4; i_en = 1'b1;
        @(negedge clk);
        x_valid = 1'b0; i_en = 1'b0;
        check("idata_pushpop", idata, 32'h3);
        pop_once();
        check("idata_pop_4", idata, 32'h4);
        pop_once();
        check("idata_empty", idata, 32'h0);
        pop_once();
        check("idata_underflow", idata, 32'h0);
        check("err_underflow", err, 2'b11);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("wr_count_cleared", wr_count, 0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("arm_waits_empty", seen, 0);
        push(32'h5);
        n = 0;
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("ready_after_push", ready, 1);
        busy = 1'b1;
        @(negedge clk);
        push(32'h6);

        bus.mce = 1'b1; bus.msel = 3'b101; bus.maddr = 17'h00000; bus.mdata_w = 20'hAAAAA;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.mce = 1'b0; busy = 1'b0;
        check("midrst_ready", ready, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_idata", idata, 0);
        check("midrst_wr_count", wr_count, 0);
        host_read(3'd5, 17'h00000, rd, ack);
        check("midrst_idle_ack", ack, 1);
        check("midrst_write_dropped", rd, 20'h0F0F0);
        pop_once();
        check("midrst_fifo_empty", err, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rnn_mem_host.md
Name: rnn_mem_host

Overview:
- Responder side of the RNN engine's memory/input interface.
- Serves engine reads from five parameter banks (msel 000..100) with 1-cycle read latency. Captures engine hidden-state writes (msel 101).
- Feeds 32-bit input vectors from a FIFO on i_en and sequences ready/busy around one inference run.
- A host port loads weights and config, and reads back results while the engine is idle.

Parameters:
- MAX_T, 16, number of timesteps the output bank stores (output bank = MAX_T*64 words)
- XFIFO_DEPTH, 8, input-vector FIFO depth (power of 2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  host pulse: begin a run
- ready  out  1  one-cycle start strobe to engine
- busy  in  1  engine busy
- i_en  in  1  engine input pop strobe
- idata  out  32  current input vector (FIFO head)
- mce  in  1  engine memory enable
- msel  in  3  bank select
- maddr  in  17  engine address
- mdata_w  in  20  engine write data
- mdata_r  out  20  read data to engine
- x_valid  in  1  host input-vector push
- x_data  in  32  host input vector
- x_ready  out  1  FIFO not full
- hst_en  in  1  host access request
- hst_we  in  1  host write (1) / read (0)
- hst_sel  in  3  host bank select
- hst_addr  in  17  host address
- hst_wdata  in  20  host write data
- hst_rdata  out  20  host read data, valid 1 cycle after accepted read
- hst_ack  out  1  host access accepted (registered, 1 cycle after request)
- done  out  1  one-cycle pulse when run completes
- wr_count  out  17  output-bank writes in last run
- err  out  2  sticky: [0] FIFO underflow, [1] out-of-range output write

Behaviour:
- Reset, synchronous: all outputs 0; FIFO emptied; FSM to IDLE; err cleared. Bank contents are not cleared.
- Bank map (addr bits beyond each bank's range are ignored):
  - 000 W_ih: 2048 words, addr[10:0] = {h[5:0], x[4:0]}
  - 001 b_ih: 64 words, addr[5:0]
  - 010 W_hh: 4096 words, addr[11:0]
  - 011 b_hh: 64 words, addr[5:0]
  - 100 config: 1 word; timestep field read by the engine
  - 101 output: addr[16:0] = {t[10:0], h[5:0]}; valid iff t < MAX_T
  - 110, 111: read 0, writes dropped
- Engine read, every cycle with mce=1 and msel != 101: mdata_r <= bank[msel][maddr] at the next edge (1-cycle latency). With mce=0, mdata_r holds its value.
- Engine write: mce=1 and msel=101 writes mdata_w to output[maddr] at that edge.
  - If t >= MAX_T: write dropped, err[1] set.
  - Each accepted write increments wr_count.
  - mdata_r holds during write cycles.
- Host access: accepted only when FSM is IDLE or DONE. Otherwise hst_ack stays 0 and the host must retry. Accepted write updates the bank at the edge; accepted read returns hst_rdata the next cycle with hst_ack.
- Input FIFO:
  - Push on x_valid & x_ready.
  - idata is registered and always shows the FIFO head; it is 0 when empty.
  - i_en=1 at an edge pops the head; idata shows the new head after that edge. The engine samples idata one cycle after raising i_en.
  - i_en on empty FIFO: no pop, idata=0, err[0] set.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- FSM:
  - IDLE: on start, clear wr_count and go to ARM.
  - ARM: wait for FIFO non-empty, then ready=1 for exactly 1 cycle and go to WAIT.
  - WAIT: on busy=1, go to RUN. If busy stays 0 for 4 cycles after the ready pulse, re-pulse ready.
  - RUN: on busy=0, done=1 for 1 cycle and go to DONE.
  - DONE: start returns to ARM (wr_count cleared).
  - start outside IDLE/DONE is ignored.
- Reset mid-run: FSM returns to IDLE immediately; a pending engine write in the same cycle is dropped.

Test Plan:
- Host writes W_ih[{h=3,x=5}]=20'h0ABCD, then engine reads msel=000, maddr=0x65 -> mdata_r=20'h0ABCD one cycle later; mce=0 next cycle -> mdata_r holds.
- Push 3 vectors 0x1, 0x2, 0x3 and pulse start -> ready pulses once; idata=0x1; i_en pulse -> idata=0x2 next cycle.
- Busy held 1 while host issues a write -> hst_ack=0, bank unchanged; after busy falls -> done pulse, and the retried write gets hst_ack=1.
- Engine writes msel=101 at maddr={t=2,h=63} with data 20'h10000 -> host readback returns 20'h10000; wr_count=1.
- Write at t=MAX_T (maddr=16<<6) -> dropped, err[1]=1; i_en with empty FIFO -> err[0]=1, idata=0.
- Reset asserted during RUN -> next cycle ready=0, done=0, FSM IDLE, FIFO empty, err=0.
